// File: rtl/gain_pkg.sv
// Shared Q4.12 coefficient types used by gain, gain_ramp and the neighbouring stages.
package gain_pkg;

    typedef logic signed [15:0] q4_12_t;

    localparam int     FRAC_BITS = 12;
    localparam q4_12_t UNITY     = 16'sh1000;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } ramp_state_t;

endpackage

// File: rtl/gain_ramp.sv
// Steps the gain coefficient toward a latched Q4.12 target by STEP per sample tick,
// flagging an active ramp and pulsing once when the target is reached.
module gain_ramp
    import gain_pkg::*;
#(
    parameter int     STEP       = 16,
    parameter q4_12_t RESET_GAIN = UNITY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] target_gain,
    input  logic               target_load,
    input  logic               sample_tick,
    output logic signed [15:0] gain_out,
    output logic               ramping,
    output logic               settled
);

    localparam logic signed [16:0] STEP_W = 17'(STEP);

    q4_12_t      cur;
    q4_12_t      tgt;
    q4_12_t      eff_tgt;
    q4_12_t      next_cur;
    ramp_state_t state;

    // 17-bit intermediates keep cur +/- STEP from wrapping before the clamp.
    function automatic q4_12_t step_toward(input q4_12_t from, input q4_12_t to,
                                           input ramp_state_t dir);
        logic signed [16:0] wide_from;
        logic signed [16:0] wide_to;
        logic signed [16:0] wide_next;
        wide_from = {from[15], from};
        wide_to   = {to[15], to};
        case (dir)
            UP: begin
                wide_next = wide_from + STEP_W;
                if (wide_next > wide_to) wide_next = wide_to;
            end
            DOWN: begin
                wide_next = wide_from - STEP_W;
                if (wide_next < wide_to) wide_next = wide_to;
            end
            default: wide_next = wide_from;
        endcase
        return q4_12_t'(wide_next[15:0]);
    endfunction

    // A load in the same cycle as a tick steers that tick toward the new target.
    always_comb begin
        eff_tgt = target_load ? target_gain : tgt;
        if (cur < eff_tgt)      state = UP;
        else if (cur > eff_tgt) state = DOWN;
        else                    state = IDLE;
        next_cur = sample_tick ? step_toward(cur, eff_tgt, state) : cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= RESET_GAIN;
            tgt     <= RESET_GAIN;
            ramping <= 1'b0;
            settled <= 1'b0;
        end else begin
            cur     <= next_cur;
            tgt     <= eff_tgt;
            ramping <= (next_cur != eff_tgt);
            settled <= (next_cur != cur) && (next_cur == eff_tgt);
        end
    end

    assign gain_out = cur;

endmodule

// File: tb/tb_gain_ramp.sv
// Directed-vector bench for gain_ramp with the default STEP=16 and unity reset gain.
module tb_gain_ramp;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] target_gain;
    logic               target_load;
    logic               sample_tick;
    logic signed [15:0] gain_out;
    logic               ramping;
    logic               settled;

    int n_compared   = 0;
    int n_mismatched = 0;
    int model_cur;

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] gain;
        logic        tick;
        logic [15:0] exp_gain;
        logic        exp_ramping;
        logic        exp_settled;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    gain_ramp dut (
        .clk        (clk),
        .rst        (rst),
        .target_gain(target_gain),
        .target_load(target_load),
        .sample_tick(sample_tick),
        .gain_out   (gain_out),
        .ramping    (ramping),
        .settled    (settled)
    );

    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] g,
                                 input logic t);
        rst         = r;
        target_load = l;
        target_gain = g;
        sample_tick = t;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        target_load = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] eg, input logic er,
                               input logic es);
        n_compared++;
        if (gain_out !== eg || ramping !== er || settled !== es) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got gain=%h ramping=%b settled=%b, expected gain=%h ramping=%b settled=%b",
                     name, gain_out, ramping, settled, eg, er, es);
        end
    endtask

    // Loads a target and ticks until the bench's own clamped-step model reaches it.
    task automatic rampTo(input logic signed [15:0] target, input string name);
        int t;
        int guard;
        t = target;
        applyStimulus(1'b0, 1'b1, target, 1'b0);
        checkOutput({name, "_load"}, model_cur[15:0], model_cur != t, 1'b0);
        guard = 0;
        while (model_cur != t && guard < 5000) begin
            if (model_cur < t) model_cur = (model_cur + 16 > t) ? t : model_cur + 16;
            else               model_cur = (model_cur - 16 < t) ? t : model_cur - 16;
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput(name, model_cur[15:0], model_cur != t, model_cur == t);
            guard++;
        end
        if (model_cur != t) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s_budget: model=%0d target=%0d", name, model_cur, t);
        end
    endtask

    initial begin
        rst         = 1'b1;
        target_load = 1'b0;
        target_gain = 16'h0000;
        sample_tick = 1'b0;

        //           rst   load  gain      tick  exp_gain  ramp  settled
        vecs[0]  = '{1'b1, 1'b1, 16'h2000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h1008, 1'b0, 16'h1000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1008, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h1008, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h1008, 1'b1, 16'h1008, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0FF0, 1'b0, 16'h1008, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0FF8, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0FF0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 16'h1100, 1'b1, 16'h1000, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].gain, vecs[i].tick);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_gain, vecs[i].exp_ramping,
                        vecs[i].exp_settled);
        end

        // Unity up to 2.0: 256 ticks of 0x10.
        applyStimulus(1'b0, 1'b1, 16'h2000, 1'b0);
        checkOutput("up_load", 16'h1000, 1'b1, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("up_tick%0d", i), 16'(32'h1000 + 16 * i), i < 256, i == 256);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput("up_extra", 16'h2000, 1'b0, 1'b0);
        end

        // 2.0 down to -1.0: 768 ticks.
        applyStimulus(1'b0, 1'b1, 16'hF000, 1'b0);
        checkOutput("down_load", 16'h2000, 1'b1, 1'b0);
        for (int i = 1; i <= 768; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("down_tick%0d", i), 16'(32'h2000 - 16 * i), i < 768, i == 768);
        end

        // Range edges: clamping must stop before any 16-bit wrap.
        model_cur = -4096;
        rampTo(16'sh7FF8, "to_7ff8");
        rampTo(16'sh7FFF, "to_7fff");
        rampTo(16'sh8008, "to_8008");
        rampTo(16'sh8000, "to_8000");

        // Retarget mid-ramp with a reversal on the same cycle as a tick.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset2", 16'h1000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h2000, 1'b0);
        checkOutput("rt_load", 16'h1000, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("rt_up%0d", i), 16'(32'h1000 + 16 * i), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 16'h1000, 1'b1);
        checkOutput("rt_reverse", 16'h1090, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("rt_down%0d", i), 16'(32'h1090 - 16 * i), i < 9, i == 9);
        end
        model_cur = 32'h1000;
        rampTo(16'sh10A0, "to_10a0");
        applyStimulus(1'b0, 1'b1, 16'h10A0, 1'b0);
        checkOutput("equal_load", 16'h10A0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h10A0, 1'b1);
        checkOutput("equal_load_tick", 16'h10A0, 1'b0, 1'b0);

        // Reset mid-ramp at 0x1500 toward 0x2000.
        model_cur = 32'h10A0;
        applyStimulus(1'b0, 1'b1, 16'h2000, 1'b0);
        checkOutput("mid_load", 16'h10A0, 1'b1, 1'b0);
        for (int i = 1; i <= 70; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        end
        checkOutput("mid_at_1500", 16'h1500, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("mid_reset", 16'h1000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput("post_reset_tick", 16'h1000, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
